// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear controller for a 4-digit BCD stopwatch.
// Synchronizes and debounces three push-buttons, divides clk to a count tick,
// and drives count-enable / clear strobes plus a lap display-hold flag.
module stopwatch_ctrl #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss_raw,
  input  logic       btn_lap_raw,
  input  logic       btn_clr_raw,
  input  logic       cnt_max,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic [2:0] state,
  output logic       running
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PS_W = $clog2(DIV);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_FULL  = 3'd4
  } state_t;

  // Button index: 0 = start/stop, 1 = lap, 2 = clear
  logic [2:0]      raw_s;
  logic [2:0]      sync1_r;
  logic [2:0]      sync2_r;
  logic [2:0]      level_r;
  logic [2:0]      level_d_r;
  logic [2:0]      press_r;
  logic [DB_W-1:0] db_cnt_r [3];

  state_t          state_r;
  state_t          next_state_s;
  logic [PS_W-1:0] presc_r;
  logic            tick_s;
  logic            sat_s;
  logic            ss_s;
  logic            lap_s;
  logic            clr_s;
  logic            cnt_en_s;
  logic            cnt_clr_s;
  logic            cnt_en_r;
  logic            cnt_clr_r;
  logic            disp_hold_r;
  logic            running_r;

  assign raw_s = {btn_clr_raw, btn_lap_raw, btn_ss_raw};

  // Synchronize, debounce and rising-edge detect each button
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r   <= 3'b000;
      sync2_r   <= 3'b000;
      level_r   <= 3'b000;
      level_d_r <= 3'b000;
      press_r   <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        db_cnt_r[i] <= {DB_W{1'b0}};
      end
    end else begin
      sync1_r   <= raw_s;
      sync2_r   <= sync1_r;
      level_d_r <= level_r;
      press_r   <= level_r & ~level_d_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] != level_r[i]) begin
          if (db_cnt_r[i] == DB_LAST) begin
            level_r[i]  <= sync2_r[i];
            db_cnt_r[i] <= {DB_W{1'b0}};
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
          end
        end else begin
          db_cnt_r[i] <= {DB_W{1'b0}};
        end
      end
    end
  end

  // Clear beats start/stop beats lap; losers in the same cycle are dropped
  assign clr_s = press_r[2];
  assign ss_s  = press_r[0] & ~press_r[2];
  assign lap_s = press_r[1] & ~press_r[2] & ~press_r[0];

  assign tick_s = ((state_r == ST_RUN) || (state_r == ST_LAP)) && (presc_r == PS_LAST);
  assign sat_s  = tick_s & cnt_max;

  // Prescaler advances while counting, keeps its phase in PAUSE, zeroed otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= {PS_W{1'b0}};
    end else begin
      case (state_r)
        ST_RUN, ST_LAP: begin
          if (tick_s) begin
            presc_r <= {PS_W{1'b0}};
          end else begin
            presc_r <= presc_r + PS_W'(1);
          end
        end
        ST_PAUSE: presc_r <= presc_r;
        default:  presc_r <= {PS_W{1'b0}};
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; saturation outranks button presses while counting
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ss_s) next_state_s = ST_RUN;
        else      next_state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (sat_s)      next_state_s = ST_FULL;
        else if (ss_s)  next_state_s = ST_PAUSE;
        else if (lap_s) next_state_s = ST_LAP;
        else            next_state_s = ST_RUN;
      end
      ST_LAP: begin
        if (sat_s)      next_state_s = ST_FULL;
        else if (ss_s)  next_state_s = ST_PAUSE;
        else if (lap_s) next_state_s = ST_RUN;
        else            next_state_s = ST_LAP;
      end
      ST_PAUSE: begin
        if (clr_s)     next_state_s = ST_IDLE;
        else if (ss_s) next_state_s = ST_RUN;
        else           next_state_s = ST_PAUSE;
      end
      ST_FULL: begin
        if (clr_s) next_state_s = ST_IDLE;
        else       next_state_s = ST_FULL;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output decode: count strobe on unsaturated ticks, clear strobe on honoured clear
  always_comb begin
    cnt_en_s  = tick_s & ~cnt_max;
    cnt_clr_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_PAUSE, ST_FULL: cnt_clr_s = clr_s;
      default:                    cnt_clr_s = 1'b0;
    endcase
  end

  // Output registers, aligned with the state transition they belong to
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_en_r    <= 1'b0;
      cnt_clr_r   <= 1'b0;
      disp_hold_r <= 1'b0;
      running_r   <= 1'b0;
    end else begin
      cnt_en_r    <= cnt_en_s;
      cnt_clr_r   <= cnt_clr_s;
      disp_hold_r <= (next_state_s == ST_LAP);
      running_r   <= (next_state_s == ST_RUN) || (next_state_s == ST_LAP);
    end
  end

  assign cnt_en    = cnt_en_r;
  assign cnt_clr   = cnt_clr_r;
  assign disp_hold = disp_hold_r;
  assign running   = running_r;
  assign state     = state_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl: directed scenarios plus random button traffic,
// all outputs compared every cycle against a behavioural reference model.
module tb_stopwatch_ctrl;

  localparam int CLK_HZ  = 100;
  localparam int TICK_HZ = 10;
  localparam int DEB     = 4;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int HL      = DEB + 2;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_LAP   = 3;
  localparam int S_FULL  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_ss_raw = 1'b0;
  logic       btn_lap_raw = 1'b0;
  logic       btn_clr_raw = 1'b0;
  logic       cnt_max = 1'b0;
  logic       cnt_en;
  logic       cnt_clr;
  logic       disp_hold;
  logic [2:0] state;
  logic       running;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;
  int p_en    = 0;
  int p_clr   = 0;

  // Reference model state (values visible after the latest rising edge)
  int          m_state;
  int          m_phase;
  bit          m_en;
  bit          m_clr;
  bit          m_lvl   [3];
  bit          m_lvl_d [3];
  bit          m_press [3];
  bit [HL-1:0] m_hist  [3];

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .CLK_HZ(CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_ss_raw(btn_ss_raw),
    .btn_lap_raw(btn_lap_raw),
    .btn_clr_raw(btn_clr_raw),
    .cnt_max(cnt_max),
    .cnt_en(cnt_en),
    .cnt_clr(cnt_clr),
    .disp_hold(disp_hold),
    .state(state),
    .running(running)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: a button level flips once the last DEB synchronized
  // samples all disagree with it; presses appear one cycle after the flip.
  always @(posedge clk) begin
    bit raw [3];
    bit tick, sat, c, s, l, flip;
    int ns;
    raw[0] = btn_ss_raw;
    raw[1] = btn_lap_raw;
    raw[2] = btn_clr_raw;
    if (reset) begin
      m_state = S_IDLE;
      m_phase = 0;
      m_en    = 1'b0;
      m_clr   = 1'b0;
      for (int b = 0; b < 3; b++) begin
        m_lvl[b]   = 1'b0;
        m_lvl_d[b] = 1'b0;
        m_press[b] = 1'b0;
        m_hist[b]  = '0;
      end
    end else begin
      tick = ((m_state == S_RUN) || (m_state == S_LAP)) && (m_phase == DIV - 1);
      sat  = tick && cnt_max;
      c = m_press[2];
      s = m_press[0] && !c;
      l = m_press[1] && !c && !s;
      ns    = m_state;
      m_en  = tick && !cnt_max;
      m_clr = 1'b0;
      case (m_state)
        S_IDLE: begin
          if (c) m_clr = 1'b1;
          else if (s) ns = S_RUN;
        end
        S_RUN, S_LAP: begin
          if (sat) ns = S_FULL;
          else if (s) ns = S_PAUSE;
          else if (l) ns = (m_state == S_RUN) ? S_LAP : S_RUN;
        end
        S_PAUSE: begin
          if (c) begin ns = S_IDLE; m_clr = 1'b1; end
          else if (s) ns = S_RUN;
        end
        S_FULL: begin
          if (c) begin ns = S_IDLE; m_clr = 1'b1; end
        end
        default: ns = S_IDLE;
      endcase
      if ((m_state == S_RUN) || (m_state == S_LAP)) m_phase = tick ? 0 : m_phase + 1;
      else if (m_state != S_PAUSE) m_phase = 0;
      m_state = ns;
      for (int b = 0; b < 3; b++) begin
        m_press[b] = m_lvl[b] && !m_lvl_d[b];
        m_lvl_d[b] = m_lvl[b];
        m_hist[b]  = {m_hist[b][HL-2:0], raw[b]};
        flip = m_lvl[b] ? (m_hist[b][HL-1:2] == '0) : (&m_hist[b][HL-1:2]);
        if (flip) m_lvl[b] = !m_lvl[b];
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [6:0] exp_v;
    if (chk_on) begin
      exp_v = {m_state[2:0], m_en, m_clr, (m_state == S_LAP),
               ((m_state == S_RUN) || (m_state == S_LAP))};
      check("cycle_outs", {state, cnt_en, cnt_clr, disp_hold, running}, exp_v);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (cnt_en)  p_en++;
      if (cnt_clr) p_clr++;
    end
  endtask

  task automatic set_btn(input logic [2:0] m);
    btn_ss_raw  = m[0];
    btn_lap_raw = m[1];
    btn_clr_raw = m[2];
  endtask

  task automatic press(input logic [2:0] m, input int hold);
    p_en  = 0;
    p_clr = 0;
    set_btn(m);
    cyc(hold);
    set_btn(3'b000);
    cyc(DEB + 6);
  endtask

  initial begin
    int n;
    int last;
    logic [2:0] m;

    reset = 1'b1;
    cyc(2);
    chk_on = 1'b1;
    cyc(1);
    check("reset_outs", {state, cnt_en, cnt_clr, disp_hold, running}, 7'd0);
    reset = 1'b0;
    cyc(2);

    // Bounce shorter than the debounce window is rejected
    set_btn(3'b001);
    cyc(3);
    set_btn(3'b000);
    cyc(12);
    check("bounce_idle", state, S_IDLE);

    // Held press: RUN exactly DEB+4 cycles after the raw rise, single transition
    set_btn(3'b001);
    cyc(DEB + 3);
    check("lat_early", state, S_IDLE);
    cyc(1);
    check("lat_run", state, S_RUN);
    cyc(20 - (DEB + 4));
    set_btn(3'b000);
    cyc(DEB + 6);
    check("hold_single", state, S_RUN);

    // 100 cycles of RUN give 10 enables spaced DIV apart
    n = 0;
    last = -1;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (cnt_en) begin
        n++;
        if (last >= 0) check("en_gap", i - last, DIV);
        last = i;
      end
    end
    check("en_count", n, 10);

    // Pause stops counting; resume returns to RUN
    press(3'b001, 6);
    check("pause_state", state, S_PAUSE);
    p_en = 0;
    cyc(30);
    check("pause_no_en", p_en, 0);
    press(3'b001, 6);
    check("resume_run", state, S_RUN);

    // Lap mode holds the display while counting continues
    press(3'b010, 6);
    check("lap_state", state, S_LAP);
    check("lap_hold", disp_hold, 1);
    p_en = 0;
    cyc(20);
    check("lap_en", p_en, 2);
    press(3'b010, 6);
    check("lap_back_run", state, S_RUN);
    check("lap_back_hold", disp_hold, 0);
    press(3'b010, 6);
    press(3'b001, 6);
    check("lap_ss_pause", state, S_PAUSE);
    check("lap_ss_hold", disp_hold, 0);

    // Saturation: no enable, FULL, start ignored, clear returns to IDLE
    press(3'b001, 6);
    cnt_max = 1'b1;
    p_en = 0;
    cyc(12);
    check("sat_full", state, S_FULL);
    check("sat_no_en", p_en, 0);
    press(3'b001, 6);
    check("full_ss_ign", state, S_FULL);
    press(3'b100, 6);
    check("full_clr_idle", state, S_IDLE);
    check("full_clr_pulse", p_clr, 1);
    cnt_max = 1'b0;

    // Clear and start together in PAUSE: clear wins
    press(3'b001, 6);
    press(3'b001, 6);
    check("prio_pause", state, S_PAUSE);
    press(3'b101, 6);
    check("prio_idle", state, S_IDLE);
    check("prio_clr", p_clr, 1);

    // Clear is ignored while running
    press(3'b001, 6);
    press(3'b100, 6);
    check("run_clr_ign", state, S_RUN);
    check("run_clr_nopulse", p_clr, 0);

    // Reset from LAP clears everything on the next cycle
    press(3'b010, 6);
    check("pre_reset_lap", state, S_LAP);
    reset = 1'b1;
    cyc(1);
    check("reset_lap", {state, cnt_en, cnt_clr, disp_hold, running}, 7'd0);
    reset = 1'b0;
    cyc(2);

    // Random button traffic, including bounces, combos, saturation and resets
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
      end
      cnt_max = ($urandom_range(0, 9) == 0);
      m = 3'b001 << $urandom_range(0, 2);
      if ($urandom_range(0, 2) == 0) m = 3'b001;
      if ($urandom_range(0, 6) == 0) m = 3'($urandom_range(1, 7));
      set_btn(m);
      cyc($urandom_range(1, 12));
      set_btn(3'b000);
      cyc($urandom_range(1, 25));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
